// File: rtl/aes_pkg.sv
// Shared AES constants: key-length codes, Nk/Nr/Nw lookups, GF(2^8) xtime, Rcon seed.
// Pure declarations; no logic, no latency.
// No flow control.
package aes_pkg;

  typedef enum logic [1:0] {
    KEYLEN_128 = 2'b00,
    KEYLEN_192 = 2'b01,
    KEYLEN_256 = 2'b10
  } keylen_t;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  localparam logic [5:0] NW_128 = 6'd44;
  localparam logic [5:0] NW_192 = 6'd52;
  localparam logic [5:0] NW_256 = 6'd60;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input keylen_t m);
    case (m)
      KEYLEN_128: return NK_128;
      KEYLEN_192: return NK_192;
      default:    return NK_256;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input keylen_t m);
    case (m)
      KEYLEN_128: return NR_128;
      KEYLEN_192: return NR_192;
      default:    return NR_256;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(input keylen_t m);
    case (m)
      KEYLEN_128: return NW_128;
      KEYLEN_192: return NW_192;
      default:    return NW_256;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four S-box lookups into one output register.
// Latency 1 cycle from rd_en to sub; sub holds its value while rd_en is low.
// No backpressure; caller issues rd_en only when it wants a fresh result.
// Ports: clk, reset_n, rd_en, word (input word), sub (registered SubWord(word)).
module aes_sub_word (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_en,
  input  logic [31:0] word,
  output logic [31:0] sub
);

  logic [31:0] sub_comb;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    s_table_ROM u_sbox (
      .addr (word[8*b +: 8]),
      .data (sub_comb[8*b +: 8])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   sub <= '0;
    else if (rd_en) sub <= sub_comb;
  end

endmodule

// File: rtl/s_table_ROM.sv
// AES forward S-box lookup table.
// Combinational, zero latency.
// No flow control.
// Ports: addr (byte in), data (substituted byte out).
module s_table_ROM (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  // Byte 0 of the table sits in the most significant position of the constant.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data = SBOX[8'd255 - addr];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion into a round-key RAM with an async read port.
// Latency last key word -> done: 51/55/66 cycles; S-box words take 2 cycles, others 1.
// key_ready high only in IDLE/LOAD; key_valid is ignored while expanding.
// Ports: clk, reset_n, key_len/key_word/key_valid/key_ready (key load), rk_addr/rk_word
// (round-key read), rk_valid, nr, busy, done. Optional: zeroize (KSCHED_ZEROIZE_EN).
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = 60,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef KSCHED_ZEROIZE_EN
  input  logic              zeroize,
`endif
  input  logic [1:0]        key_len,
  input  logic [31:0]       key_word,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [ADDR_W-1:0] rk_addr,
  output logic [31:0]       rk_word,
  output logic              rk_valid,
  output logic [3:0]        nr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, EXPAND, DONE
`ifdef KSCHED_ZEROIZE_EN
    , ZERO
`endif
  } state_t;

  state_t            state, state_nxt;
  keylen_t           mode, mode_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [2:0]        cnt, cnt_nxt;      // idx mod Nk, avoids a divider
  logic              phase, phase_nxt;  // 0: issue S-box read, 1: write result
  logic [7:0]        rcon, rcon_nxt;
  logic              rk_valid_nxt;

  logic [31:0]       key_ram [MAX_WORDS];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  logic [ADDR_W-1:0] nk_a, nw_a;
  logic [31:0]       temp, prev, sub, sub_in;
  logic              need_sub, rot_step, sub_rd;

  assign nk_a     = ADDR_W'(nk_of(mode));
  assign nw_a     = ADDR_W'(nw_of(mode));
  assign temp     = key_ram[idx - ADDR_W'(1)];
  assign prev     = key_ram[idx - nk_a];
  assign rot_step = (cnt == 3'd0);
  assign need_sub = rot_step || ((mode == KEYLEN_256) && (cnt == 3'd4));
  assign sub_in   = rot_step ? {temp[23:0], temp[31:24]} : temp;

  assign nr      = nr_of(mode);
  assign rk_word = key_ram[rk_addr];

  aes_sub_word u_sub_word (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_en   (sub_rd),
    .word    (sub_in),
    .sub     (sub)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mode     <= KEYLEN_256;
      idx      <= '0;
      cnt      <= '0;
      phase    <= 1'b0;
      rcon     <= RCON_INIT;
      rk_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      phase    <= phase_nxt;
      rcon     <= rcon_nxt;
      rk_valid <= rk_valid_nxt;
    end
  end

  // RAM is deliberately not reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (we) key_ram[waddr] <= wdata;
  end

  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    phase_nxt    = phase;
    rcon_nxt     = rcon;
    rk_valid_nxt = rk_valid;
    we           = 1'b0;
    waddr        = idx;
    wdata        = key_word;
    sub_rd       = 1'b0;
    key_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          we           = 1'b1;
          waddr        = '0;
          mode_nxt     = key_len[1] ? KEYLEN_256 : keylen_t'(key_len);
          rk_valid_nxt = 1'b0;
          idx_nxt      = ADDR_W'(1);
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        key_ready = 1'b1;
        busy      = 1'b1;
        if (key_valid) begin
          we      = 1'b1;
          idx_nxt = idx + ADDR_W'(1);
          if (idx == nk_a - ADDR_W'(1)) begin
            cnt_nxt   = '0;
            phase_nxt = 1'b0;
            rcon_nxt  = RCON_INIT;
            state_nxt = EXPAND;
          end
        end
      end
      EXPAND: begin
        busy = 1'b1;
        if (need_sub && !phase) begin
          sub_rd    = 1'b1;
          phase_nxt = 1'b1;
        end else begin
          we        = 1'b1;
          phase_nxt = 1'b0;
          if (need_sub)
            wdata = prev ^ sub ^ (rot_step ? {rcon, 24'h0} : 32'h0);
          else
            wdata = prev ^ temp;
          if (rot_step) rcon_nxt = xtime(rcon);
          cnt_nxt = ({1'b0, cnt} == nk_of(mode) - 4'd1) ? 3'd0 : cnt + 3'd1;
          idx_nxt = idx + ADDR_W'(1);
          if (idx == nw_a - ADDR_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        rk_valid_nxt = 1'b1;
        state_nxt    = IDLE;
      end
`ifdef KSCHED_ZEROIZE_EN
      ZERO: begin
        busy    = 1'b1;
        we      = 1'b1;
        wdata   = 32'h0;
        idx_nxt = idx + ADDR_W'(1);
        if (idx == ADDR_W'(MAX_WORDS - 1)) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase

`ifdef KSCHED_ZEROIZE_EN
    // Zeroize overrides whatever the current state was doing this cycle.
    if (zeroize) begin
      we           = 1'b0;
      sub_rd       = 1'b0;
      key_ready    = 1'b0;
      done         = 1'b0;
      busy         = 1'b1;
      idx_nxt      = '0;
      rk_valid_nxt = 1'b0;
      state_nxt    = ZERO;
    end
`endif
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 appendix A key expansions.
// Drives inputs 1 time unit after the rising edge, samples outputs at the same point.
// Optional zeroize checks when KSCHED_ZEROIZE_EN is defined.
module tb_aes_key_schedule;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  key_len;
  logic [31:0] key_word;
  logic        key_valid;
  logic        key_ready;
  logic [5:0]  rk_addr;
  logic [31:0] rk_word;
  logic        rk_valid;
  logic [3:0]  nr;
  logic        busy;
  logic        done;
`ifdef KSCHED_ZEROIZE_EN
  logic        zeroize;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] kbuf [8];
  int lat;

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef KSCHED_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .key_len   (key_len),
    .key_word  (key_word),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_addr   (rk_addr),
    .rk_word   (rk_word),
    .rk_valid  (rk_valid),
    .nr        (nr),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_word(input string tag, input int a, input logic [31:0] exp);
    rk_addr = 6'(a);
    #1;
    check(tag, rk_word, exp);
  endtask

  // Loads kbuf[0..nk-1]; optional 5-cycle valid gap before word gap_at; optional
  // junk key_valid during expansion. Returns cycles from last accept to done.
  task automatic load_key(input logic [1:0] len, input int nk, input int gap_at,
                          input bit poke, output int latency);
    latency = -1;
    for (int i = 0; i < nk; i++) begin
      if (i == gap_at) begin
        key_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
      end
      key_valid = 1'b1;
      key_word  = kbuf[i];
      key_len   = (i == 0) ? len : ~len;  // later key_len changes must be ignored
      @(posedge clk);
      #1;
      if (i == 0) begin
        check("rkv_clear", {31'd0, rk_valid}, 32'd0);
        check("busy_load", {31'd0, busy}, 32'd1);
      end
    end
    key_valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n == 5) check("rkv_expand", {31'd0, rk_valid}, 32'd0);
      if (poke && n == 10) begin
        key_valid = 1'b1;
        key_word  = 32'hdeadbeef;
        check("rdy_expand", {31'd0, key_ready}, 32'd0);
      end
      if (poke && n == 20) key_valid = 1'b0;
      if (done) begin
        latency = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (latency < 0) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("rkv_after", {31'd0, rk_valid}, 32'd1);
    check("rdy_after", {31'd0, key_ready}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    key_len   = 2'b00;
    key_word  = 32'h0;
    key_valid = 1'b0;
    rk_addr   = 6'd0;
`ifdef KSCHED_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    #12;
    check("rst_ready", {31'd0, key_ready}, 32'd1);
    check("rst_rkv", {31'd0, rk_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_nr", {28'd0, nr}, 32'd14);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // AES-128 (A.1)
    kbuf = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 0, 0, 0, 0};
    load_key(2'b00, 4, -1, 1'b0, lat);
    check("lat128", lat, 32'd51);
    check("nr128", {28'd0, nr}, 32'd10);
    read_word("w128_0", 0, 32'h2b7e1516);
    read_word("w128_4", 4, 32'ha0fafe17);
    read_word("w128_43", 43, 32'hb6630ca6);

    // AES-192 (A.2)
    kbuf = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
             32'h62f8ead2, 32'h522c6b7b, 0, 0};
    load_key(2'b01, 6, -1, 1'b0, lat);
    check("lat192", lat, 32'd55);
    check("nr192", {28'd0, nr}, 32'd12);
    read_word("w192_5", 5, 32'h522c6b7b);
    read_word("w192_6", 6, 32'hfe0c91f7);
    read_word("w192_51", 51, 32'h01002202);

    // AES-256 (A.3) with a load gap and key_valid poked during expansion
    kbuf = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
             32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
    load_key(2'b10, 8, 4, 1'b1, lat);
    check("lat256", lat, 32'd66);
    check("nr256", {28'd0, nr}, 32'd14);
    read_word("w256_8", 8, 32'h9ba35411);
    read_word("w256_12", 12, 32'ha8b09c1a);
    read_word("w256_59", 59, 32'h706c631e);

`ifdef KSCHED_ZEROIZE_EN
    begin
      int nb;
      int nz;
      @(posedge clk);
      #1;
      zeroize = 1'b1;
      @(posedge clk);
      #1;
      zeroize = 1'b0;
      check("z_ready", {31'd0, key_ready}, 32'd0);
      check("z_rkv", {31'd0, rk_valid}, 32'd0);
      nb = 0;
      for (int n = 0; n < 200 && busy; n++) begin
        nb++;
        @(posedge clk);
        #1;
      end
      check("z_busy_cycles", nb, 32'd60);
      check("z_ready_after", {31'd0, key_ready}, 32'd1);
      check("z_rkv_after", {31'd0, rk_valid}, 32'd0);
      nz = 0;
      for (int a = 0; a < 60; a++) begin
        rk_addr = 6'(a);
        #1;
        if (rk_word !== 32'h0) nz++;
      end
      check("z_nonzero_words", nz, 32'd0);
    end
`endif

    // Reset during expansion, then reload A.1
    kbuf = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_word  = kbuf[i];
      key_len   = 2'b00;
      @(posedge clk);
      #1;
    end
    key_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rkv", {31'd0, rk_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, key_ready}, 32'd1);
    check("mid_rst_nr", {28'd0, nr}, 32'd14);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    load_key(2'b00, 4, -1, 1'b0, lat);
    check("lat128_re", lat, 32'd51);
    read_word("w128_re_43", 43, 32'hb6630ca6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
